// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: multi-digit BCD up/down counter with load sanitising and a one-hot digit scanner
module bcd_scan_counter #(
  parameter int DIGITS = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  En,
  input  logic                  UpDn,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadIn,
  output logic [4*DIGITS-1:0]   CountOut,
  output logic [3:0]            BCDOut,
  output logic [DIGITS-1:0]     DigitSel,
  output logic                  CarryOut,
  output logic                  LoadErr
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [4*DIGITS-1:0] nxt, ld;
  logic [3:0] d;
  logic prop, bad, scan_wrap;
  logic [IW-1:0] idx, idx_n;
  logic [PW-1:0] pre;
  // prop ripples the decade carry/borrow through the digits; its final value marks a full wrap
  always_comb begin
    nxt = CountOut;
    ld = LoadIn;
    bad = 1'b0;
    prop = 1'b1;
    d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = CountOut[4*k +: 4];
      if (prop) nxt[4*k +: 4] = UpDn ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
      prop = prop & (UpDn ? d == 4'd9 : d == 4'd0);
      if (LoadIn[4*k +: 4] > 4'd9) begin
        ld[4*k +: 4] = 4'd0;
        bad = 1'b1;
      end
    end
  end
  assign scan_wrap = pre == PW'(SCAN_DIV - 1);
  assign idx_n = idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
  assign BCDOut = CountOut[{idx, 2'b00} +: 4];
  always_ff @(posedge clk) begin
    if (rst) begin
      CountOut <= '0;
      CarryOut <= 1'b0;
      LoadErr <= 1'b0;
      pre <= '0;
      idx <= '0;
      DigitSel <= DIGITS'(1);
    end else begin
      CarryOut <= 1'b0;
      LoadErr <= 1'b0;
      if (Load) begin
        CountOut <= ld;
        LoadErr <= bad;
      end else if (En) begin
        CountOut <= nxt;
        CarryOut <= prop;
      end
      pre <= scan_wrap ? '0 : pre + 1'b1;
      if (scan_wrap) begin
        idx <= idx_n;
        DigitSel <= DIGITS'(1) << idx_n;
      end
    end
  end
endmodule
